// File: rtl/flappy_bird_motion.sv
// Bird vertical-motion engine: gravity, flap impulse, ceiling/floor limits
// and an IDLE/FLY/DEAD game FSM, advanced once per video frame.
module flappy_bird_motion #(
    parameter int          BIRD_X    = 160,
    parameter int          BIRD_SIZE = 8,
    parameter int          Y_START   = 240,
    parameter int          Y_MAX     = 479,
    parameter int          GRAVITY   = 1,
    parameter int          FLAP_VEL  = -8,
    parameter int          VEL_MAX   = 10,
    parameter logic [7:0]  FLAP_KEY  = 8'h2C,
    parameter int          DEAD_HOLD = 60
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_vs,
    input  logic [7:0] keycode,
    input  logic       hit,
    output logic [9:0] BirdX,
    output logic [9:0] BirdY,
    output logic [9:0] BirdS,
    output logic [7:0] vel,
    output logic [1:0] state,
    output logic       dead
);

    localparam int HW = $clog2(DEAD_HOLD + 1);

    localparam logic        [9:0]    Y_START_V = 10'(Y_START);
    localparam logic        [9:0]    Y_FLOOR_V = 10'(Y_MAX - BIRD_SIZE);
    localparam logic        [9:0]    Y_CEIL_V  = 10'(BIRD_SIZE);
    localparam logic signed [10:0]   NY_FLOOR  = 11'(Y_MAX - BIRD_SIZE);
    localparam logic signed [10:0]   NY_CEIL   = 11'(BIRD_SIZE);
    localparam logic signed [7:0]    FLAP_V    = 8'(FLAP_VEL);
    localparam logic signed [7:0]    VMAX_V    = 8'(VEL_MAX);
    localparam logic signed [7:0]    GRAV_V    = 8'(GRAVITY);
    localparam logic        [HW-1:0] HOLD_MAX  = HW'(DEAD_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FLY  = 2'b01,
        DEAD = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic        [9:0]  y_q, y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic        [HW-1:0] hold_q, hold_d;
    logic               dead_q;

    logic vs_s1, vs_s2, vs_s3;
    logic tick;
    logic key_d;
    logic key_match, press;
    logic flap_req;
    logic flap;

    logic signed [10:0] ny;
    logic signed [7:0]  vel_grav;

    assign key_match = (keycode == FLAP_KEY);
    assign press     = key_match & ~key_d;
    assign flap      = flap_req | press;

    // VS synchroniser, falling-edge frame tick and key edge register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
            vs_s3 <= 1'b1;
            tick  <= 1'b0;
            key_d <= 1'b0;
        end else begin
            vs_s1 <= frame_vs;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
            tick  <= vs_s3 & ~vs_s2;
            key_d <= key_match;
        end
    end

    // Flap request latch: a press in the tick cycle is folded into that tick via 'flap'
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            flap_req <= 1'b0;
        else if (tick)
            flap_req <= 1'b0;
        else if (press)
            flap_req <= 1'b1;
    end

    // Next-frame position/velocity arithmetic
    always_comb begin
        ny       = $signed({1'b0, y_q}) + $signed({{3{vel_q[7]}}, vel_q});
        vel_grav = (vel_q + GRAV_V > VMAX_V) ? VMAX_V : vel_q + GRAV_V;
    end

    // Game FSM next-state and motion update, evaluated only on frame ticks
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        hold_d  = hold_q;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    y_d   = Y_START_V;
                    vel_d = '0;
                    if (flap) begin
                        state_d = FLY;
                        vel_d   = FLAP_V;
                    end
                end
                FLY: begin
                    vel_d = flap ? FLAP_V : vel_grav;
                    // floor check precedes ceiling check so a floor hit always wins
                    if (ny >= NY_FLOOR) begin
                        y_d     = Y_FLOOR_V;
                        vel_d   = '0;
                        state_d = DEAD;
                        hold_d  = '0;
                    end else if (ny < NY_CEIL) begin
                        y_d   = Y_CEIL_V;
                        vel_d = '0;
                    end else begin
                        y_d = ny[9:0];
                    end
                    if (hit) begin
                        state_d = DEAD;
                        hold_d  = '0;
                    end
                end
                DEAD: begin
                    if (flap && hold_q == HOLD_MAX) begin
                        state_d = IDLE;
                        y_d     = Y_START_V;
                        vel_d   = '0;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    y_d     = Y_START_V;
                    vel_d   = '0;
                end
            endcase
        end
    end

    // Registered game state and outputs
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            y_q     <= Y_START_V;
            vel_q   <= '0;
            hold_q  <= '0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            hold_q  <= hold_d;
            dead_q  <= (state_d == DEAD);
        end
    end

    assign BirdX = 10'(BIRD_X);
    assign BirdS = 10'(BIRD_SIZE);
    assign BirdY = y_q;
    assign vel   = vel_q;
    assign state = state_q;
    assign dead  = dead_q;

endmodule

// File: tb/tb_flappy_bird_motion.sv
// Directed bench for flappy_bird_motion with a frame-level scoreboard.
module tb_flappy_bird_motion;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_vs = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       hit = 1'b0;
    logic [9:0] BirdX, BirdY, BirdS;
    logic [7:0] vel;
    logic [1:0] state;
    logic       dead;

    flappy_bird_motion dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .frame_vs (frame_vs),
        .keycode  (keycode),
        .hit      (hit),
        .BirdX    (BirdX),
        .BirdY    (BirdY),
        .BirdS    (BirdS),
        .vel      (vel),
        .state    (state),
        .dead     (dead)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] y;
        logic [7:0] v;
        logic [1:0] s;
        logic       d;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_state, m_y, m_vel, m_hold;
    bit m_req, m_key;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        assert (act === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, expv);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0; m_y = 240; m_vel = 0; m_hold = 0; m_req = 0; m_key = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.y = 10'(m_y);
        e.v = 8'(m_vel);
        e.s = 2'(m_state);
        e.d = (m_state == 2);
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".y"},     16'(BirdY), 16'(e.y));
            chk({tag, ".vel"},   16'(vel),   16'(e.v));
            chk({tag, ".state"}, 16'(state), 16'(e.s));
            chk({tag, ".dead"},  16'(dead),  16'(e.d));
        end
    endtask

    task automatic set_key(input logic [7:0] k);
        keycode = k;
        if (k == 8'h2C && !m_key) m_req = 1;
        m_key = (k == 8'h2C);
    endtask

    task automatic model_tick(input bit h);
        int ny, nv;
        case (m_state)
            0: if (m_req) begin m_state = 1; m_vel = -8; end
            1: begin
                ny = m_y + m_vel;
                nv = m_req ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
                if (ny >= 471) begin m_y = 471; nv = 0; m_state = 2; m_hold = 0; end
                else if (ny < 8) begin m_y = 8; nv = 0; end
                else m_y = ny;
                m_vel = nv;
                if (h) begin m_state = 2; m_hold = 0; end
            end
            default: begin
                if (m_req && m_hold == 60) begin m_state = 0; m_y = 240; m_vel = 0; end
                else if (m_hold < 60) m_hold++;
            end
        endcase
        m_req = 0;
    endtask

    // one video frame: optional press (released unless held), VS low pulse, then compare
    task automatic frame(input bit do_press, input bit keep_key, input bit h, input string tag);
        if (do_press) begin
            set_key(8'h2C);
            wait_clks(2);
            if (!keep_key) set_key(8'h00);
        end
        hit = h;
        model_tick(h);
        push_exp();
        frame_vs = 1'b0;
        wait_clks(8);
        frame_vs = 1'b1;
        wait_clks(8);
        hit = 1'b0;
        @(negedge Clk);
        pop_chk(tag);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        wait_clks(2);
        Reset_n = 1'b1;
        model_reset();
        wait_clks(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();

        // 1. reset state
        do_reset();
        push_exp();
        @(negedge Clk);
        pop_chk("reset");
        chk("birdx", 16'(BirdX), 16'd160);
        chk("birds", 16'(BirdS), 16'd8);

        // 2. first flap and two following frames
        frame(1, 0, 0, "flap_start");
        chk("flap_start_vel", 16'(vel), 16'(8'hF8));
        chk("flap_start_y", 16'(BirdY), 16'd240);
        frame(0, 0, 0, "tick2");
        frame(0, 0, 0, "tick3");
        chk("tick3_y", 16'(BirdY), 16'd225);
        chk("tick3_vel", 16'(vel), 16'(8'hFA));

        // 3. held key gives one flap; velocity reaches terminal value
        frame(1, 1, 0, "held0");
        for (int i = 1; i < 20; i++) frame(0, 0, 0, "held");
        set_key(8'h00);
        for (int i = 0; i < 12; i++) frame(0, 0, 0, "sat");
        chk("sat_vel", 16'(vel), 16'd10);

        // 4. free fall to floor, DEAD hold and restart
        for (int i = 0; i < 30 && m_state != 2; i++) frame(0, 0, 0, "fall");
        chk("floor_y", 16'(BirdY), 16'd471);
        chk("floor_state", 16'(state), 16'd2);
        chk("floor_dead", 16'(dead), 16'd1);
        for (int i = 0; i < 29; i++) frame(0, 0, 0, "dead_hold");
        frame(1, 0, 0, "dead_press30");
        chk("dead30_state", 16'(state), 16'd2);
        for (int i = 0; i < 30; i++) frame(0, 0, 0, "dead_hold2");
        frame(1, 0, 0, "restart");
        chk("restart_state", 16'(state), 16'd0);
        chk("restart_y", 16'(BirdY), 16'd240);

        // 5. ceiling clamp under repeated flaps, then pipe hit
        frame(1, 0, 0, "fly_again");
        for (int i = 0; i < 30; i++) begin
            frame(1, 0, 0, "ceiling");
            checks++;
            assert (BirdY >= 10'd8) else begin
                errors++;
                $error("FAIL ceiling_min: observed %0d expected >= 8", BirdY);
            end
        end
        chk("ceiling_y", 16'(BirdY), 16'd8);
        chk("ceiling_vel", 16'(vel), 16'd0);
        frame(0, 0, 1, "hit");
        chk("hit_state", 16'(state), 16'd2);
        chk("hit_dead", 16'(dead), 16'd1);

        // 6. reset mid-FLY while a press and a VS fall are in flight
        do_reset();
        frame(1, 0, 0, "fly_pre_reset");
        chk("pre_reset_state", 16'(state), 16'd1);
        keycode = 8'h2C;
        frame_vs = 1'b0;
        Reset_n = 1'b0;
        wait_clks(6);
        keycode = 8'h00;
        frame_vs = 1'b1;
        wait_clks(2);
        Reset_n = 1'b1;
        model_reset();
        wait_clks(4);
        push_exp();
        @(negedge Clk);
        pop_chk("mid_reset");
        frame(0, 0, 0, "post_reset_tick");
        chk("post_reset_state", 16'(state), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
